// File: rtl/dmem_pkg.sv
// dmem_pkg: shared MMIO offsets, error bit indices and region decode
// type for the data-memory responder.
package dmem_pkg;

  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_CYCLE  = 4'h8;
  localparam logic [3:0] OFF_ERR    = 4'hC;

  localparam int ERR_MISALIGN = 0;
  localparam int ERR_UNMAPPED = 1;
  localparam int ERR_OVF      = 2;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_MMIO,
    REG_NONE
  } region_e;

endpackage

// File: rtl/dmem_tx_fifo.sv
// dmem_tx_fifo: parameterised synchronous FIFO for the console TX path.
// Head reads 0 when empty; a pop frees a slot for a same-cycle push.
module dmem_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (PW+1)'(DEPTH));
  assign count   = cnt_q;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rd_q];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= wdata;
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: word RAM plus MMIO page (TX FIFO, cycle counter, errors).
// CYCLE register is built only when DMEM_CYCLE_CNT_EN is defined.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          RAM_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
  parameter int          TXF_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_ce_i,
  input  logic        data_we_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        err_o
);

  localparam int          AW        = $clog2(RAM_WORDS);
  localparam int          CW        = $clog2(TXF_DEPTH) + 1;
  localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);

  logic [31:0]   mem [RAM_WORDS];
  region_e       region;
  logic [3:0]    off;
  logic          misal, ld, st, is_ram, is_mmio;
  logic          push, ovf, f_full, f_empty;
  logic [CW-1:0] f_cnt;
  logic [2:0]    err_q, err_d, err_set, err_clr;
  logic [31:0]   cyc_rd;

  always_comb begin
    if (data_addr_i[31:4] == MMIO_BASE[31:4]) region = REG_MMIO;
    else if (data_addr_i < RAM_BYTES)         region = REG_RAM;
    else                                      region = REG_NONE;
  end

  assign off     = data_addr_i[3:0];
  assign misal   = |data_addr_i[1:0];
  assign is_ram  = (region == REG_RAM);
  assign is_mmio = (region == REG_MMIO);
  assign ld      = data_ce_i & ~data_we_i & ~misal;
  assign st      = data_ce_i & data_we_i & ~misal;

  always_comb begin
    data_o = '0;
    if (ld) begin
      unique case (1'b1)
        is_ram:  data_o = mem[data_addr_i[AW+1:2]];
        is_mmio: begin
          case (off)
            OFF_STATUS: data_o = {20'b0, 8'(f_cnt), 2'b0, f_full, f_empty};
            OFF_CYCLE:  data_o = cyc_rd;
            OFF_ERR:    data_o = {29'b0, err_q};
            default:    data_o = '0;
          endcase
        end
        default: data_o = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (st & is_ram) mem[data_addr_i[AW+1:2]] <= data_i;
  end

  // A full FIFO still takes the push when the sink pops in the same cycle.
  assign push = st & is_mmio & (off == OFF_TXDATA);
  assign ovf  = push & f_full & ~tx_ready_i;

  dmem_tx_fifo #(
    .DEPTH (TXF_DEPTH),
    .W     (8)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (push),
    .wdata (data_i[7:0]),
    .pop   (tx_ready_i),
    .rdata (tx_data_o),
    .full  (f_full),
    .empty (f_empty),
    .count (f_cnt)
  );

  assign tx_valid_o = ~f_empty;

  always_comb begin
    err_set               = '0;
    err_set[ERR_MISALIGN] = data_ce_i & misal;
    err_set[ERR_UNMAPPED] = data_ce_i & (region == REG_NONE);
    err_set[ERR_OVF]      = ovf;
    err_clr = (st & is_mmio & (off == OFF_ERR)) ? data_i[2:0] : '0;
    err_d   = (err_q & ~err_clr) | err_set;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= '0;
    else      err_q <= err_d;
  end

  assign err_o = |err_q;

`ifdef DMEM_CYCLE_CNT_EN
  logic [31:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q + 32'd1;
    if (st & is_mmio & (off == OFF_CYCLE)) cyc_d = data_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cyc_q <= '0;
    else      cyc_q <= cyc_d;
  end

  assign cyc_rd = cyc_q;
`else
  assign cyc_rd = '0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed stimulus against a queue/array model of
// the responder, checked every cycle plus literal spot checks.
module tb_dmem_responder;

  localparam logic [31:0] MB = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce = 1'b0;
  logic        we = 1'b0;
  logic        ready = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [7:0]  txd;
  logic        txv;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram_m [int];
  logic [7:0]  q_m [$];
  logic [31:0] cyc_m = '0;
  logic [2:0]  err_m = '0;
  logic [7:0]  cap [$];

  dmem_responder dut (
    .clk         (clk),
    .rst         (rst),
    .data_ce_i   (ce),
    .data_we_i   (we),
    .data_addr_i (addr),
    .data_i      (wdata),
    .data_o      (rdata),
    .tx_data_o   (txd),
    .tx_valid_o  (txv),
    .tx_ready_i  (ready),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  function automatic logic is_mm(input logic [31:0] a);
    return a[31:4] == MB[31:4];
  endfunction

  function automatic void step();
    logic [2:0]  set;
    logic [2:0]  clr;
    logic [31:0] nxt;
    logic        al;
    set = '0;
    clr = '0;
    nxt = cyc_m + 32'd1;
    al  = (addr[1:0] == 2'b00);
    if (ready && q_m.size() > 0) void'(q_m.pop_front());
    if (ce && !al) set[0] = 1'b1;
    if (ce && !is_mm(addr) && addr >= 32'd4096) set[1] = 1'b1;
    if (ce && we && al) begin
      if (is_mm(addr)) begin
        case (addr[3:0])
          4'h0: if (q_m.size() < 8) q_m.push_back(wdata[7:0]);
                else set[2] = 1'b1;
          4'h8: nxt = wdata;
          4'hC: clr = wdata[2:0];
          default: ;
        endcase
      end else if (addr < 32'd4096) begin
        ram_m[int'(addr[11:2])] = wdata;
      end
    end
`ifdef DMEM_CYCLE_CNT_EN
    cyc_m = nxt;
`else
    cyc_m = '0;
`endif
    err_m = (err_m & ~clr) | set;
  endfunction

  function automatic logic exp_load(output logic [31:0] v);
    int n;
    v = '0;
    n = q_m.size();
    if (!ce || we || addr[1:0] != 2'b00) return 1'b1;
    if (is_mm(addr)) begin
      case (addr[3:0])
        4'h4: v = {20'b0, 8'(n), 2'b0, n == 8, n == 0};
        4'h8: v = cyc_m;
        4'hC: v = {29'b0, err_m};
        default: v = '0;
      endcase
    end else if (addr < 32'd4096) begin
      if (!ram_m.exists(int'(addr[11:2]))) return 1'b0;
      v = ram_m[int'(addr[11:2])];
    end
    return 1'b1;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        q_m.delete();
        cyc_m = '0;
        err_m = '0;
      end else begin
        step();
      end
    end
  end

  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (exp_load(e)) chk("data_o", rdata, e);
      chk("tx_valid", txv, q_m.size() > 0);
      chk("tx_data", txd, q_m.size() > 0 ? q_m[0] : 8'h00);
      chk("err_o", err, |err_m);
      if (txv && ready) cap.push_back(txd);
    end
  end

  task automatic drv(input logic c, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic r);
    @(posedge clk);
    #1;
    ce = c; we = w; addr = a; wdata = d; ready = r;
    @(negedge clk);
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d,
                    input logic r);
    drv(1'b1, 1'b1, a, d, r);
  endtask

  task automatic ld(input logic [31:0] a);
    drv(1'b1, 1'b0, a, '0, 1'b0);
  endtask

  task automatic idle(input logic r);
    drv(1'b0, 1'b0, '0, '0, r);
  endtask

  initial begin
    #2;
    chk("rst_txv", txv, 0);
    chk("rst_txd", txd, 0);
    chk("rst_err", err, 0);
    chk("rst_data", rdata, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    st(32'h10, 32'hDEADBEEF, 1'b0);
    ld(32'h10);
    chk("ram_rd", rdata, 32'hDEADBEEF);
    ld(MB + 4);
    chk("status_empty", rdata, 32'h1);

    ld(32'h13);
    chk("misal_rd", rdata, 0);
    ld(MB + 12);
    chk("err_misal", rdata, 32'h1);
    chk("err_o_set", err, 1);
    st(MB + 12, 32'h1, 1'b0);
    ld(MB + 12);
    chk("err_clr", rdata, 0);
    chk("err_o_clr", err, 0);

    ld(32'h1000);
    chk("unmap_rd", rdata, 0);
    ld(MB + 12);
    chk("err_unmap", rdata, 32'h2);
    st(32'h20, 32'hCAFEF00D, 1'b0);
    st(32'h22, 32'h12345678, 1'b0);
    ld(32'h20);
    chk("misal_st_ign", rdata, 32'hCAFEF00D);
    st(MB + 12, 32'h7, 1'b0);

    cap.delete();
    st(MB, 32'h41, 1'b0);
    st(MB, 32'h42, 1'b0);
    st(MB, 32'h43, 1'b0);
    ld(MB + 4);
    chk("status_cnt3", rdata, 32'h30);
    repeat (4) idle(1'b1);
    chk("cap3_n", cap.size(), 3);
    if (cap.size() == 3) begin
      chk("cap3_0", cap[0], 8'h41);
      chk("cap3_1", cap[1], 8'h42);
      chk("cap3_2", cap[2], 8'h43);
    end

    cap.delete();
    for (int i = 0; i < 9; i++) st(MB, 32'h50 + i, 1'b0);
    ld(MB + 4);
    chk("status_full", rdata, 32'h82);
    ld(MB + 12);
    chk("err_ovf", rdata, 32'h4);
    chk("head_stable", txd, 8'h50);
    repeat (10) idle(1'b1);
    chk("cap8_n", cap.size(), 8);
    if (cap.size() == 8) chk("cap8_last", cap[7], 8'h57);
    st(MB + 12, 32'h7, 1'b0);

    for (int i = 0; i < 8; i++) st(MB, 32'h60 + i, 1'b0);
    cap.delete();
    st(MB, 32'h70, 1'b1);
    ld(MB + 4);
    chk("full_pushpop", rdata, 32'h82);
    ld(MB + 12);
    chk("no_ovf", rdata, 0);
    repeat (10) idle(1'b1);
    chk("cap9_n", cap.size(), 9);
    if (cap.size() == 9) begin
      chk("cap9_0", cap[0], 8'h60);
      chk("cap9_8", cap[8], 8'h70);
    end

    st(MB + 8, 32'hFFFF_FFFE, 1'b0);
    idle(1'b0);
    ld(MB + 8);
`ifdef DMEM_CYCLE_CNT_EN
    chk("cyc_max", rdata, 32'hFFFF_FFFF);
`else
    chk("cyc_off", rdata, 0);
`endif
    ld(MB + 8);
    chk("cyc_wrap", rdata, 0);
    ld(MB + 12);
    chk("cyc_noerr", rdata, 0);

    for (int i = 0; i < 4; i++) st(MB, 32'h80 + i, 1'b0);
    idle(1'b0);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_v", txv, 0);
    chk("rst_mid_d", txd, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    idle(1'b1);
    chk("post_rst_v", txv, 0);
    ld(MB + 4);
    chk("post_rst_st", rdata, 32'h1);

    idle(1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
